// File: rtl/cv32e40x_rf_write_buffer_if.sv
// cv32e40x_rf_write_buffer_if: EX/LSU inputs and register-file write-port outputs of the write buffer
interface cv32e40x_rf_write_buffer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                            ex_valid_i;
  logic                            ex_ready_o;
  logic [ADDR_WIDTH-1:0]           ex_rd_i;
  logic                            ex_dual_i;
  logic [DATA_WIDTH-1:0]           ex_wdata_lo_i;
  logic [DATA_WIDTH-1:0]           ex_wdata_hi_i;
  logic                            lsu_valid_i;
  logic [ADDR_WIDTH-1:0]           lsu_rd_i;
  logic [DATA_WIDTH-1:0]           lsu_wdata_i;
  logic                            dualwrite_o;
  logic [ADDR_WIDTH-1:0]           waddr_o;
  logic [1:0][DATA_WIDTH-1:0]      wdata_o;
  logic [1:0]                      we_o;
  logic [31:0]                     pending_o;
  logic                            waw_err_o;
  modport slave (
    input  ex_valid_i, ex_rd_i, ex_dual_i, ex_wdata_lo_i, ex_wdata_hi_i,
           lsu_valid_i, lsu_rd_i, lsu_wdata_i,
    output ex_ready_o, dualwrite_o, waddr_o, wdata_o, we_o, pending_o, waw_err_o
  );
  modport master (
    output ex_valid_i, ex_rd_i, ex_dual_i, ex_wdata_lo_i, ex_wdata_hi_i,
           lsu_valid_i, lsu_rd_i, lsu_wdata_i,
    input  ex_ready_o, dualwrite_o, waddr_o, wdata_o, we_o, pending_o, waw_err_o
  );
endinterface

// File: rtl/cv32e40x_rf_write_buffer.sv
// cv32e40x_rf_write_buffer: EX result FIFO merged with priority LSU writebacks into one RF write per cycle
module cv32e40x_rf_write_buffer #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic                       clk,
  input logic                       rst,
  cv32e40x_rf_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic                  dual;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] hi;
  } entry_t;
  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  entry_t                head;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  waw_err_q, waw_err_d;
  logic                  push, pop, lsu;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0]           pending;
  assign head = mem_q[rd_ptr_q];
  assign base = {head.rd[ADDR_WIDTH-1:1], 1'b0};
  assign lsu  = !rst && bus.lsu_valid_i;
  assign pop  = !rst && !bus.lsu_valid_i && cnt_q != '0;
  assign push = bus.ex_valid_i && bus.ex_ready_o;
  assign bus.ex_ready_o  = !rst && cnt_q != CW'(DEPTH);
  assign bus.dualwrite_o = pop && head.dual;
  assign bus.waddr_o     = lsu ? bus.lsu_rd_i : pop ? (head.dual ? base : head.rd) : '0;
  assign bus.wdata_o[0]  = lsu ? bus.lsu_wdata_i : pop ? head.lo : '0;
  assign bus.wdata_o[1]  = bus.dualwrite_o ? head.hi : '0;
  assign bus.we_o[0]     = lsu ? bus.lsu_rd_i != '0 : pop && (head.dual ? base != '0 : head.rd != '0);
  assign bus.we_o[1]     = bus.dualwrite_o;
  assign bus.pending_o   = pending;
  assign bus.waw_err_o   = waw_err_q;
  // Entry i is live when its distance from the read pointer is below the count
  always_comb begin
    pending = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if (CW'(off) < cnt_q)
        pending |= mem_q[i].dual ? (32'(3) << {mem_q[i].rd[ADDR_WIDTH-1:1], 1'b0})
                                 : (32'(1) << mem_q[i].rd);
    end
    pending[0] = 1'b0;
    if (rst) pending = '0;
  end
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    waw_err_d = waw_err_q | (lsu && bus.lsu_rd_i != '0 && pending[bus.lsu_rd_i]);
    if (push) mem_d[wr_ptr_q] = '{rd: bus.ex_rd_i, dual: bus.ex_dual_i,
                                  lo: bus.ex_wdata_lo_i, hi: bus.ex_wdata_hi_i};
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      waw_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      waw_err_q <= waw_err_d;
    end
  end
endmodule

// File: tb/tb_cv32e40x_rf_write_buffer.sv
// tb_cv32e40x_rf_write_buffer: directed vectors with hand-computed expectations
module tb_cv32e40x_rf_write_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  cv32e40x_rf_write_buffer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();
  cv32e40x_rf_write_buffer #(.DEPTH(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #2;
  endtask
  task automatic idle();
    bus.ex_valid_i = 1'b0; bus.ex_rd_i = '0; bus.ex_dual_i = 1'b0;
    bus.ex_wdata_lo_i = '0; bus.ex_wdata_hi_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = '0; bus.lsu_wdata_i = '0;
  endtask
  task automatic ex(input logic [4:0] rd, input logic dual, input logic [31:0] lo, input logic [31:0] hi);
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = rd; bus.ex_dual_i = dual;
    bus.ex_wdata_lo_i = lo; bus.ex_wdata_hi_i = hi;
  endtask
  task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid_i = v; bus.lsu_rd_i = rd; bus.lsu_wdata_i = d;
  endtask
  initial begin
    idle();
    // reset held for three edges
    step(); settle();
    chk("rst_ready", 64'(bus.ex_ready_o), 0);
    chk("rst_we", 64'(bus.we_o), 0);
    chk("rst_pending", 64'(bus.pending_o), 0);
    step(); step();
    rst = 1'b0;
    step(); settle();
    chk("idle_ready", 64'(bus.ex_ready_o), 1);
    chk("idle_we", 64'(bus.we_o), 0);
    chk("idle_waddr", 64'(bus.waddr_o), 0);
    chk("idle_pending", 64'(bus.pending_o), 0);
    chk("idle_waw", 64'(bus.waw_err_o), 0);
    // single write
    step();
    ex(5, 0, 32'hDEADBEEF, 32'h0);
    settle();
    chk("s_ready", 64'(bus.ex_ready_o), 1);
    step(); idle(); settle();
    chk("s_waddr", 64'(bus.waddr_o), 5);
    chk("s_we", 64'(bus.we_o), 2'b01);
    chk("s_dual", 64'(bus.dualwrite_o), 0);
    chk("s_wdata", 64'(bus.wdata_o), 64'h00000000_DEADBEEF);
    chk("s_pending", 64'(bus.pending_o), 32'h20);
    step(); settle();
    chk("s_pending_popped", 64'(bus.pending_o), 0);
    chk("s_we_empty", 64'(bus.we_o), 0);
    // dual write rd=7 aligns to 6
    ex(7, 1, 32'h11, 32'h22);
    step(); idle(); settle();
    chk("d_dual", 64'(bus.dualwrite_o), 1);
    chk("d_waddr", 64'(bus.waddr_o), 6);
    chk("d_we", 64'(bus.we_o), 2'b11);
    chk("d_wdata", 64'(bus.wdata_o), 64'h00000022_00000011);
    chk("d_pending", 64'(bus.pending_o), 32'hC0);
    step();
    ex(1, 1, 32'h33, 32'h44);
    step(); idle(); settle();
    chk("d1_waddr", 64'(bus.waddr_o), 0);
    chk("d1_we", 64'(bus.we_o), 2'b10);
    chk("d1_pending", 64'(bus.pending_o), 32'h2);
    step(); settle();
    chk("d1_pending_popped", 64'(bus.pending_o), 0);
    // back-pressure under four LSU cycles
    lsu(1, 20, 32'hCAFEF00D);
    ex(3, 0, 32'h3, 0);
    settle();
    chk("bp_lsu_waddr", 64'(bus.waddr_o), 20);
    chk("bp_lsu_we", 64'(bus.we_o), 2'b01);
    chk("bp_lsu_wdata", 64'(bus.wdata_o), 64'h00000000_CAFEF00D);
    step();
    ex(4, 0, 32'h4, 0);
    settle();
    chk("bp_ready1", 64'(bus.ex_ready_o), 1);
    step();
    ex(9, 0, 32'h9, 0);
    settle();
    chk("bp_full_ready", 64'(bus.ex_ready_o), 0);
    chk("bp_full_pending", 64'(bus.pending_o), 32'h18);
    step(); settle();
    chk("bp_hold_ready", 64'(bus.ex_ready_o), 0);
    step();
    lsu(0, 0, 0);
    settle();
    chk("bp_no_popthru", 64'(bus.ex_ready_o), 0);
    chk("bp_issue3", 64'(bus.waddr_o), 3);
    step(); settle();
    chk("bp_issue4", 64'(bus.waddr_o), 4);
    chk("bp_ready_again", 64'(bus.ex_ready_o), 1);
    step(); idle(); settle();
    chk("bp_issue9", 64'(bus.waddr_o), 9);
    chk("bp_pending9", 64'(bus.pending_o), 32'h200);
    chk("bp_no_waw", 64'(bus.waw_err_o), 0);
    step(); settle();
    chk("bp_empty_we", 64'(bus.we_o), 0);
    // ten back-to-back push/pop transactions wrap the pointers
    ex(1, 0, 32'h100, 0);
    step();
    for (int k = 1; k < 10; k++) begin
      ex(5'(k + 1), 0, 32'h100 + 32'(k), 0);
      settle();
      chk("pp_waddr", 64'(bus.waddr_o), 64'(k));
      chk("pp_wdata", 64'(bus.wdata_o), 64'h100 + 64'(k - 1));
      chk("pp_ready", 64'(bus.ex_ready_o), 1);
      step();
    end
    idle(); settle();
    chk("pp_last", 64'(bus.waddr_o), 10);
    step(); settle();
    chk("pp_drained", 64'(bus.we_o), 0);
    // LSU write to x0
    lsu(1, 0, 32'h5);
    settle();
    chk("x0_we", 64'(bus.we_o), 0);
    chk("x0_waddr", 64'(bus.waddr_o), 0);
    step(); idle(); settle();
    chk("x0_no_waw", 64'(bus.waw_err_o), 0);
    // WAW: LSU hits a pending EX destination
    ex(12, 0, 32'h12, 0);
    step(); idle();
    lsu(1, 12, 32'hAAAA);
    settle();
    chk("waw_lsu_waddr", 64'(bus.waddr_o), 12);
    chk("waw_lsu_wdata", 64'(bus.wdata_o), 64'hAAAA);
    chk("waw_before", 64'(bus.waw_err_o), 0);
    step(); idle(); settle();
    chk("waw_set", 64'(bus.waw_err_o), 1);
    chk("waw_fifo_kept", 64'(bus.wdata_o), 64'h12);
    step(); settle();
    chk("waw_sticky", 64'(bus.waw_err_o), 1);
    // reset with two entries queued
    lsu(1, 20, 32'h1);
    ex(13, 0, 32'hD, 0);
    step();
    ex(14, 0, 32'hE, 0);
    step();
    bus.ex_valid_i = 1'b0;
    settle();
    chk("mq_pending", 64'(bus.pending_o), 32'h6000);
    chk("mq_full", 64'(bus.ex_ready_o), 0);
    rst = 1'b1;
    idle(); settle();
    chk("mq_rst_pending", 64'(bus.pending_o), 0);
    chk("mq_rst_we", 64'(bus.we_o), 0);
    step();
    rst = 1'b0;
    settle();
    chk("mq_after_pending", 64'(bus.pending_o), 0);
    chk("mq_after_waw", 64'(bus.waw_err_o), 0);
    chk("mq_after_we", 64'(bus.we_o), 0);
    chk("mq_after_ready", 64'(bus.ex_ready_o), 1);
    step(); settle();
    chk("mq_still_empty", 64'(bus.we_o), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
